// File: rtl/leaf_nic.sv
// leaf_nic: synchronous network interface for one leaf port of the 8-leaf
// asynchronous router tree.
//   TX: local requests are buffered in a FIFO, packed as {dest[2:0], payload[7:0]}
//       and driven into the tree with a 4-phase bundled-data handshake.
//   RX: packets from the tree are accepted with the same handshake. Packets
//       addressed to this leaf go to the RX FIFO; others are discarded and
//       flagged on the sticky misroute output.
// The tree-side control inputs (out_ack, in_req) are asynchronous and pass
// through SYNC_STAGES-deep synchronisers before use.
// Optional build macro LEAF_NIC_STATS_EN adds saturating tx_count/rx_count outputs.
module leaf_nic #(
    parameter int unsigned NODE_ID     = 0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [2:0]  tx_dest,
    input  logic [7:0]  tx_payload,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_payload,
    output logic [10:0] out_data,
    output logic        out_req,
    input  logic        out_ack,
    input  logic [10:0] in_data,
    input  logic        in_req,
    output logic        in_ack,
`ifdef LEAF_NIC_STATS_EN
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
`endif
    output logic        misroute
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  NODE_ADDR = 3'(NODE_ID);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {
        T_IDLE,
        T_SETUP,
        T_REQ,
        T_REL
    } tx_state_e;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_state_e;

    // ------------------------------------------------------------------
    // Synchronisers for the asynchronous handshake inputs
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   ack_s;
    logic                   req_s;

    // Shift the raw tree-side ack/req through the synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
            req_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], out_ack};
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], in_req};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign req_s = req_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // TX FIFO (pointers carry one extra wrap bit to tell full from empty)
    // ------------------------------------------------------------------
    logic [10:0] tx_mem_q [FIFO_DEPTH];
    logic [AW:0] tx_wr_q;
    logic [AW:0] tx_rd_q;
    logic        tx_empty;
    logic        tx_full;
    logic        tx_push;
    logic        tx_pop;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                      (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    // Store the packed packet word at the write pointer.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q[AW-1:0]] <= {tx_dest, tx_payload};
        end
    end

    // Advance TX FIFO pointers on push and on pop by the TX FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_q <= tx_wr_q + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX handshake FSM
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q;
    tx_state_e   tx_state_d;
    logic [10:0] out_data_q;
    logic [10:0] out_data_d;
    logic        out_req_q;
    logic        out_req_d;

    // TX state, output packet register and request line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= T_IDLE;
            out_data_q <= '0;
            out_req_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            out_data_q <= out_data_d;
            out_req_q  <= out_req_d;
        end
    end

    // TX next state: load a packet, let it settle one cycle, then run the
    // 4-phase cycle. out_data only changes in T_IDLE, so it is stable for
    // the whole time out_req or ack_s is high.
    always_comb begin
        tx_state_d = tx_state_q;
        out_data_d = out_data_q;
        out_req_d  = out_req_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    out_data_d = tx_mem_q[tx_rd_q[AW-1:0]];
                    tx_state_d = T_SETUP;
                end
            end
            T_SETUP: begin
                out_req_d  = 1'b1;
                tx_state_d = T_REQ;
            end
            T_REQ: begin
                if (ack_s) begin
                    out_req_d  = 1'b0;
                    tx_state_d = T_REL;
                end
            end
            T_REL: begin
                if (!ack_s) begin
                    tx_state_d = T_IDLE;
                end
            end
            default: begin
                out_req_d  = 1'b0;
                tx_state_d = T_IDLE;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign out_req  = out_req_q;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [AW:0] rx_wr_q;
    logic [AW:0] rx_rd_q;
    logic        rx_empty;
    logic        rx_full;
    logic        rx_capture;
    logic        rx_push;
    logic        rx_pop;
    logic        dest_match;

    assign rx_empty   = (rx_wr_q == rx_rd_q);
    assign rx_full    = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                        (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign dest_match = (in_data[10:8] == NODE_ADDR);
    assign rx_push    = rx_capture && dest_match;
    assign rx_pop     = !rx_empty && rx_ready;
    assign rx_valid   = !rx_empty;
    assign rx_payload = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[AW-1:0]];

    // Store the payload of an accepted packet. in_data is bundled with
    // in_req and has been stable for the whole synchroniser delay.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= in_data[7:0];
        end
    end

    // Advance RX FIFO pointers on accepted push and on local pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX handshake FSM
    // ------------------------------------------------------------------
    rx_state_e rx_state_q;
    rx_state_e rx_state_d;
    logic      in_ack_q;
    logic      in_ack_d;
    logic      misroute_q;
    logic      misroute_d;

    // RX state, acknowledge line and sticky misroute flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            in_ack_q   <= 1'b0;
            misroute_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            in_ack_q   <= in_ack_d;
            misroute_q <= misroute_d;
        end
    end

    // RX next state: capture once per request phase, and only while a
    // FIFO slot is free so a full FIFO back-pressures the tree by
    // withholding the acknowledge.
    always_comb begin
        rx_state_d = rx_state_q;
        in_ack_d   = in_ack_q;
        misroute_d = misroute_q;
        rx_capture = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (req_s && !rx_full) begin
                    rx_capture = 1'b1;
                    in_ack_d   = 1'b1;
                    rx_state_d = R_ACK;
                    if (!dest_match) begin
                        misroute_d = 1'b1;
                    end
                end
            end
            R_ACK: begin
                if (!req_s) begin
                    in_ack_d   = 1'b0;
                    rx_state_d = R_IDLE;
                end
            end
            default: begin
                in_ack_d   = 1'b0;
                rx_state_d = R_IDLE;
            end
        endcase
    end

    assign in_ack   = in_ack_q;
    assign misroute = misroute_q;

`ifdef LEAF_NIC_STATS_EN
    // ------------------------------------------------------------------
    // Traffic statistics
    // ------------------------------------------------------------------
    logic [15:0] tx_count_q;
    logic [15:0] rx_count_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count completed request phases on TX and accepted payloads on RX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            if ((tx_state_q == T_REQ) && ack_s) begin
                tx_count_q <= sat_inc(tx_count_q);
            end
            if (rx_push) begin
                rx_count_q <= sat_inc(rx_count_q);
            end
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_leaf_nic.sv
// Directed testbench for leaf_nic (NODE_ID=2, FIFO_DEPTH=4, SYNC_STAGES=2).
// Build with +define+LEAF_NIC_STATS_EN to also exercise the counters.
module tb_leaf_nic;

    localparam int NODE_ID     = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk;
    logic        rst_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  tx_dest;
    logic [7:0]  tx_payload;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_payload;
    logic [10:0] out_data;
    logic        out_req;
    logic        out_ack;
    logic [10:0] in_data;
    logic        in_req;
    logic        in_ack;
    logic        misroute;
`ifdef LEAF_NIC_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    leaf_nic #(
        .NODE_ID     (NODE_ID),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_dest    (tx_dest),
        .tx_payload (tx_payload),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_payload (rx_payload),
        .out_data   (out_data),
        .out_req    (out_req),
        .out_ack    (out_ack),
        .in_data    (in_data),
        .in_req     (in_req),
        .in_ack     (in_ack),
`ifdef LEAF_NIC_STATS_EN
        .tx_count   (tx_count),
        .rx_count   (rx_count),
`endif
        .misroute   (misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  dest;
        logic [7:0]  payload;
        logic [10:0] exp_data;
    } tx_vec_t;

    typedef struct {
        logic [10:0] data;
        logic        exp_valid;
        logic [7:0]  exp_payload;
        logic        exp_mis;
    } rx_vec_t;

    tx_vec_t tx_tab [5];
    rx_vec_t rx_tab [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_req(input logic lvl, output int cyc);
        cyc = 0;
        while (out_req !== lvl && cyc < 100) begin
            tick();
            cyc++;
        end
        check("out_req reaches level", 32'(out_req), 32'(lvl));
    endtask

    task automatic wait_in_ack(input logic lvl, output int cyc);
        cyc = 0;
        while (in_ack !== lvl && cyc < 100) begin
            tick();
            cyc++;
        end
        check("in_ack reaches level", 32'(in_ack), 32'(lvl));
    endtask

    // Tree-side receiver: ack 3 cycles after req, release after req falls.
    task automatic tx_handshake(input logic [10:0] exp, input string tag);
        int   cyc;
        logic stable;
        wait_out_req(1'b1, cyc);
        check({tag, " out_data"}, 32'(out_data), 32'(exp));
        stable = 1'b1;
        repeat (3) begin
            tick();
            if (out_data !== exp || out_req !== 1'b1) stable = 1'b0;
        end
        out_ack = 1'b1;
        cyc = 0;
        while (out_req === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (out_data !== exp) stable = 1'b0;
        end
        check({tag, " req fall latency"}, 32'(cyc), 32'(SYNC_STAGES + 1));
        out_ack = 1'b0;
        repeat (SYNC_STAGES + 1) begin
            tick();
            if (out_data !== exp) stable = 1'b0;
        end
        check({tag, " out_data stable"}, 32'(stable), 32'(1));
    endtask

    // Tree-side sender: full 4-phase cycle, returns req-to-ack latency.
    task automatic rx_send(input logic [10:0] d, output int lat);
        int c2;
        in_data = d;
        in_req  = 1'b1;
        wait_in_ack(1'b1, lat);
        in_req = 1'b0;
        wait_in_ack(1'b0, c2);
    endtask

    task automatic rx_pop_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [7:0]  exp_q [5];

        tx_tab[0] = '{3'd1, 8'h11, 11'h111};
        tx_tab[1] = '{3'd7, 8'hFF, 11'h7FF};
        tx_tab[2] = '{3'd0, 8'h00, 11'h000};
        tx_tab[3] = '{3'd2, 8'h5A, 11'h25A};
        tx_tab[4] = '{3'd4, 8'hC3, 11'h4C3};

        rx_tab[0] = '{11'h23C, 1'b1, 8'h3C, 1'b0};
        rx_tab[1] = '{11'h655, 1'b0, 8'h00, 1'b1};
        rx_tab[2] = '{11'h281, 1'b1, 8'h81, 1'b1};
        rx_tab[3] = '{11'h200, 1'b1, 8'h00, 1'b1};

        rst_n      = 1'b0;
        tx_valid   = 1'b0;
        tx_dest    = '0;
        tx_payload = '0;
        rx_ready   = 1'b0;
        out_ack    = 1'b0;
        in_data    = '0;
        in_req     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst tx_ready", 32'(tx_ready), 32'(1));
        check("rst rx_valid", 32'(rx_valid), 32'(0));
        check("rst rx_payload", 32'(rx_payload), 32'(0));
        check("rst out_data", 32'(out_data), 32'(0));
        check("rst out_req", 32'(out_req), 32'(0));
        check("rst in_ack", 32'(in_ack), 32'(0));
        check("rst misroute", 32'(misroute), 32'(0));
`ifdef LEAF_NIC_STATS_EN
        check("rst tx_count", 32'(tx_count), 32'(0));
        check("rst rx_count", 32'(rx_count), 32'(0));
`endif
        rst_n = 1'b1;
        tick();

        // Single TX packet: data settles one cycle before req
        tx_dest    = 3'd5;
        tx_payload = 8'hA7;
        tx_valid   = 1'b1;
        check("t1 tx_ready", 32'(tx_ready), 32'(1));
        tick();
        tx_valid = 1'b0;
        tick();
        check("t1 setup out_data", 32'(out_data), 32'(11'h5A7));
        check("t1 setup out_req", 32'(out_req), 32'(0));
        tx_handshake(11'h5A7, "t1");

        // Five pushes with no ack: four queued plus one in out_data
        for (int i = 0; i < 5; i++) begin
            tx_dest    = tx_tab[i].dest;
            tx_payload = tx_tab[i].payload;
            tx_valid   = 1'b1;
            check($sformatf("t2 tx_ready before push %0d", i), 32'(tx_ready), 32'(1));
            tick();
        end
        tx_valid = 1'b0;
        check("t2 tx_ready full", 32'(tx_ready), 32'(0));
        for (int i = 0; i < 5; i++) begin
            tx_handshake(tx_tab[i].exp_data, $sformatf("t2 pkt%0d", i));
        end
        repeat (10) tick();
        check("t2 no extra packet", 32'(out_req), 32'(0));
        check("t2 tx_ready drained", 32'(tx_ready), 32'(1));

        // RX table: destination check, payload and sticky misroute
        for (int i = 0; i < 4; i++) begin
            rx_send(rx_tab[i].data, lat);
            check($sformatf("t3 ack latency %0d", i), 32'(lat), 32'(SYNC_STAGES + 1));
            check($sformatf("t3 rx_valid %0d", i), 32'(rx_valid), 32'(rx_tab[i].exp_valid));
            if (rx_tab[i].exp_valid) begin
                check($sformatf("t3 rx_payload %0d", i), 32'(rx_payload), 32'(rx_tab[i].exp_payload));
                rx_pop_one();
                check($sformatf("t3 rx_valid after pop %0d", i), 32'(rx_valid), 32'(0));
            end
            check($sformatf("t3 misroute %0d", i), 32'(misroute), 32'(rx_tab[i].exp_mis));
        end

        // RX FIFO full: backpressure, then one pop lets the fifth packet in
        exp_q[0] = 8'h10;
        exp_q[1] = 8'h20;
        exp_q[2] = 8'h30;
        exp_q[3] = 8'h40;
        exp_q[4] = 8'h50;
        for (int i = 0; i < 4; i++) begin
            rx_send({3'd2, exp_q[i]}, lat);
        end
        in_data = {3'd2, exp_q[4]};
        in_req  = 1'b1;
        repeat (10) tick();
        check("t4 in_ack held while full", 32'(in_ack), 32'(0));
        check("t4 head while full", 32'(rx_payload), 32'(8'h10));
        rx_pop_one();
        wait_in_ack(1'b1, lat);
        in_req = 1'b0;
        wait_in_ack(1'b0, lat);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t4 drain valid %0d", i), 32'(rx_valid), 32'(1));
            check($sformatf("t4 drain payload %0d", i), 32'(rx_payload), 32'(exp_q[i]));
            rx_pop_one();
        end
        check("t4 empty after drain", 32'(rx_valid), 32'(0));

        // Reset in the middle of both handshakes
        tx_dest    = 3'd3;
        tx_payload = 8'h33;
        tx_valid   = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_out_req(1'b1, lat);
        in_data = 11'h2AB;
        in_req  = 1'b1;
        wait_in_ack(1'b1, lat);
        check("t5 rx_valid before reset", 32'(rx_valid), 32'(1));
        check("t5 misroute before reset", 32'(misroute), 32'(1));
`ifdef LEAF_NIC_STATS_EN
        check("t5 tx_count before reset", 32'(tx_count), 32'(6));
        check("t5 rx_count before reset", 32'(rx_count), 32'(9));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 out_req async drop", 32'(out_req), 32'(0));
        check("t5 in_ack async drop", 32'(in_ack), 32'(0));
        in_req  = 1'b0;
        out_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("t5 tx_ready", 32'(tx_ready), 32'(1));
        check("t5 rx_valid", 32'(rx_valid), 32'(0));
        check("t5 misroute", 32'(misroute), 32'(0));
        check("t5 out_data", 32'(out_data), 32'(0));
        check("t5 out_req", 32'(out_req), 32'(0));
        check("t5 in_ack", 32'(in_ack), 32'(0));
`ifdef LEAF_NIC_STATS_EN
        check("t5 tx_count", 32'(tx_count), 32'(0));
        check("t5 rx_count", 32'(rx_count), 32'(0));
`endif
        repeat (10) tick();
        check("t5 no resumed packet", 32'(out_req), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
